// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data accesses win at grant; every access holds the port for LAT cycles, after which the FSM returns to IDLE.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    input  logic              IfFlush,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] MemAddr,
    input  logic [DATA_W-1:0] MemWData,
    output logic              RamEn,
    output logic              RamWe,
    output logic [ADDR_W-1:0] RamAddr,
    output logic [DATA_W-1:0] RamWData,
    input  logic [DATA_W-1:0] RamRData,
    output logic [DATA_W-1:0] IfRData,
    output logic              IfValid,
    output logic [DATA_W-1:0] MemRData,
    output logic              MemDone,
    output logic              IfStall,
    output logic              MemStall
);

    localparam int CNT_W = $clog2(LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT - 1);

    typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC} state_t;

    state_t state_reg, state_next;

    logic [CNT_W-1:0]  cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              we_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] mem_rdata_reg;
    logic              if_valid_reg;
    logic              mem_done_reg;
    logic              flush_seen_reg;

    logic dreq, dpend, ipend;
    logic last_cycle, grant_mem, grant_if;

    always_comb begin
        dreq       = MemRead | MemWrite;
        dpend      = dreq & ~mem_done_reg;
        ipend      = IfReq & ~if_valid_reg & ~IfFlush;
        last_cycle = (state_reg != IDLE) && (cnt_reg == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_mem  = 1'b0;
        grant_if   = 1'b0;
        case (state_reg)
            IDLE: begin
                // The load/store belongs to the older instruction, so it goes first.
                if (dpend) begin
                    state_next = MEM_ACC;
                    grant_mem  = 1'b1;
                end else if (ipend) begin
                    state_next = IF_ACC;
                    grant_if   = 1'b1;
                end
            end
            IF_ACC, MEM_ACC: begin
                if (last_cycle) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg        <= '0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            we_reg         <= 1'b0;
            if_rdata_reg   <= '0;
            mem_rdata_reg  <= '0;
            if_valid_reg   <= 1'b0;
            mem_done_reg   <= 1'b0;
            flush_seen_reg <= 1'b0;
        end else begin
            mem_done_reg <= 1'b0;

            if (grant_mem) begin
                addr_reg  <= MemAddr;
                wdata_reg <= MemWData;
                we_reg    <= MemWrite;
                cnt_reg   <= '0;
            end else if (grant_if) begin
                addr_reg  <= IfAddr;
                we_reg    <= 1'b0;
                cnt_reg   <= '0;
            end else if (state_reg != IDLE) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            // A flush anywhere inside a fetch poisons its result.
            if (state_reg == IF_ACC && !last_cycle) begin
                flush_seen_reg <= flush_seen_reg | IfFlush;
            end else begin
                flush_seen_reg <= 1'b0;
            end

            if (state_reg == MEM_ACC && last_cycle) begin
                mem_done_reg <= 1'b1;
                if (!we_reg) begin
                    mem_rdata_reg <= RamRData;
                end
            end

            if (IfFlush || (if_valid_reg && !dpend)) begin
                if_valid_reg <= 1'b0;
            end else if (state_reg == IF_ACC && last_cycle && !flush_seen_reg) begin
                if_valid_reg <= 1'b1;
                if_rdata_reg <= RamRData;
            end
        end
    end

    assign RamEn    = (state_reg != IDLE);
    assign RamWe    = (state_reg == MEM_ACC) && we_reg;
    assign RamAddr  = addr_reg;
    assign RamWData = wdata_reg;
    assign IfRData  = if_rdata_reg;
    assign IfValid  = if_valid_reg;
    assign MemRData = mem_rdata_reg;
    assign MemDone  = mem_done_reg;
    assign MemStall = dpend;
    assign IfStall  = IfReq & ~if_valid_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random load/store/fetch
// transactions checked against a word-array memory model and access-timing rules.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        IfReq, IfFlush, MemRead, MemWrite;
    logic [31:0] IfAddr, MemAddr, MemWData;
    logic        RamEn, RamWe;
    logic [31:0] RamAddr, RamWData, RamRData;
    logic [31:0] IfRData, MemRData;
    logic        IfValid, MemDone, IfStall, MemStall;

    int checks = 0;
    int errors = 0;

    // memory behind the port: data is only valid in the last cycle of an access
    logic [31:0] ram [0:255];
    logic        mem_init;
    int          en_run = 0;
    int          ram_en_cycles = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .IfReq(IfReq), .IfAddr(IfAddr), .IfFlush(IfFlush),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemWData(MemWData),
        .RamEn(RamEn), .RamWe(RamWe), .RamAddr(RamAddr), .RamWData(RamWData), .RamRData(RamRData),
        .IfRData(IfRData), .IfValid(IfValid), .MemRData(MemRData), .MemDone(MemDone),
        .IfStall(IfStall), .MemStall(MemStall)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [7:0] i);
        if (i == 8'd16) return 32'hDEADBEEF;
        return {8'hC0, i, ~i, i ^ 8'h5A};
    endfunction

    assign RamRData = (RamEn && en_run == LAT - 1) ? ram[RamAddr[9:2]] : (32'hBADC0DE0 ^ RamAddr);

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(8'(i));
        end else if (RamEn && RamWe && en_run == LAT - 1) begin
            ram[RamAddr[9:2]] <= RamWData;
        end
        en_run        <= RamEn ? en_run + 1 : 0;
        ram_en_cycles <= ram_en_cycles + (RamEn ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] model_mem [0:255];
    logic [31:0] exp_mrd;
    int          en_base;
    int          kind, done_at, valid_at, pulses;
    logic        do_mem, do_wr, do_if;
    logic [7:0]  d_idx, i_idx;
    logic [31:0] d_addr, i_addr, wdat, got_mrd, got_ird, exp_ird, exp_ld;

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        IfReq = 1'b0; IfFlush = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        IfAddr = '0; MemAddr = '0; MemWData = '0;
        for (int i = 0; i < 256; i++) model_mem[i] = init_word(8'(i));
        repeat (3) @(posedge clk);
        #1; rst = 1'b0; mem_init = 1'b0; #1;
        chk("rst_ramen", RamEn, 0);
        chk("rst_ramwe", RamWe, 0);
        chk("rst_memdone", MemDone, 0);
        chk("rst_ifvalid", IfValid, 0);
        chk("rst_mrdata", MemRData, 0);
        chk("rst_memstall", MemStall, 0);

        // isolated load
        next_cycle(); MemRead = 1'b1; MemAddr = 32'h40; #1;
        chk("lw_c0_stall", MemStall, 1);
        chk("lw_c0_en", RamEn, 0);
        for (int c = 1; c <= LAT; c++) begin
            next_cycle(); #1;
            chk("lw_acc_stall", MemStall, 1);
            chk("lw_acc_en", RamEn, 1);
            chk("lw_acc_addr", RamAddr, 32'h40);
            chk("lw_acc_we", RamWe, 0);
        end
        next_cycle(); #1;
        chk("lw_done", MemDone, 1);
        chk("lw_rdata", MemRData, 32'hDEADBEEF);
        chk("lw_done_stall", MemStall, 0);
        chk("lw_done_en", RamEn, 0);
        next_cycle(); MemRead = 1'b0; #1;
        chk("lw_done_pulse", MemDone, 0);
        exp_mrd = 32'hDEADBEEF;

        // simultaneous fetch and load
        next_cycle(); IfReq = 1'b1; IfAddr = 32'h100; MemRead = 1'b1; MemAddr = 32'h44; #1;
        chk("both_c0_ifstall", IfStall, 1);
        for (int c = 1; c <= LAT; c++) begin
            next_cycle(); #1;
            chk("both_mem_addr", RamAddr, 32'h44);
            chk("both_mem_en", RamEn, 1);
            chk("both_mem_ifstall", IfStall, 1);
        end
        next_cycle(); #1;
        chk("both_memdone", MemDone, 1);
        chk("both_mrdata", MemRData, model_mem[17]);
        chk("both_done_ifstall", IfStall, 1);
        exp_mrd = model_mem[17];
        for (int c = LAT + 2; c <= 2 * LAT + 1; c++) begin
            next_cycle(); MemRead = 1'b0; #1;
            chk("both_if_addr", RamAddr, 32'h100);
            chk("both_if_en", RamEn, 1);
            chk("both_if_ifstall", IfStall, 1);
            chk("both_if_valid", IfValid, 0);
        end
        next_cycle(); #1;
        chk("both_ifvalid", IfValid, 1);
        chk("both_irdata", IfRData, model_mem[64]);
        chk("both_ifstall_low", IfStall, 0);
        next_cycle(); IfReq = 1'b0; #1;
        chk("both_ifvalid_consumed", IfValid, 0);

        // store
        next_cycle(); MemWrite = 1'b1; MemAddr = 32'h80; MemWData = 32'h12345678; #1;
        for (int c = 1; c <= LAT; c++) begin
            next_cycle(); #1;
            chk("sw_we", RamWe, 1);
            chk("sw_addr", RamAddr, 32'h80);
            chk("sw_wdata", RamWData, 32'h12345678);
        end
        next_cycle(); #1;
        chk("sw_done", MemDone, 1);
        chk("sw_mrdata_kept", MemRData, exp_mrd);
        next_cycle(); MemWrite = 1'b0; #1;
        chk("sw_done_pulse", MemDone, 0);
        model_mem[32] = 32'h12345678;

        // fetch result held while a following load stalls the pipeline
        next_cycle(); IfReq = 1'b1; IfAddr = 32'h200; #1;
        en_base = ram_en_cycles;
        next_cycle(); MemRead = 1'b1; MemAddr = 32'h48; #1;
        chk("hold_c1_memstall", MemStall, 1);
        chk("hold_c1_addr", RamAddr, 32'h200);
        for (int c = 2; c <= LAT; c++) begin
            next_cycle(); #1;
        end
        next_cycle(); #1;
        chk("hold_ifvalid", IfValid, 1);
        chk("hold_irdata", IfRData, model_mem[128]);
        chk("hold_memstall", MemStall, 1);
        chk("hold_ifstall", IfStall, 0);
        for (int c = LAT + 2; c <= 2 * LAT + 1; c++) begin
            next_cycle(); #1;
            chk("hold_acc_ifvalid", IfValid, 1);
            chk("hold_acc_irdata", IfRData, model_mem[128]);
            chk("hold_acc_addr", RamAddr, 32'h48);
        end
        next_cycle(); #1;
        chk("hold_memdone", MemDone, 1);
        chk("hold_ifvalid_last", IfValid, 1);
        chk("hold_memstall_low", MemStall, 0);
        exp_mrd = model_mem[18];
        next_cycle(); MemRead = 1'b0; IfReq = 1'b0; #1;
        chk("hold_ifvalid_cleared", IfValid, 0);
        next_cycle(); #1;
        chk("hold_no_refetch", 32'(ram_en_cycles - en_base), 32'(2 * LAT));
        chk("hold_idle_en", RamEn, 0);

        // flush during a fetch
        next_cycle(); IfReq = 1'b1; IfAddr = 32'h300; #1;
        next_cycle(); IfFlush = 1'b1; IfAddr = 32'h304; #1;
        chk("flush_addr_kept", RamAddr, 32'h300);
        chk("flush_en", RamEn, 1);
        for (int c = 2; c <= LAT; c++) begin
            next_cycle(); IfFlush = 1'b0; #1;
        end
        next_cycle(); IfFlush = 1'b0; #1;
        chk("flush_ifvalid", IfValid, 0);
        chk("flush_idle_en", RamEn, 0);
        chk("flush_ifstall", IfStall, 1);
        for (int c = LAT + 2; c <= 2 * LAT + 1; c++) begin
            next_cycle(); #1;
            chk("flush_refetch_addr", RamAddr, 32'h304);
            chk("flush_refetch_en", RamEn, 1);
        end
        next_cycle(); #1;
        chk("flush_new_valid", IfValid, 1);
        chk("flush_new_irdata", IfRData, model_mem[193]);
        next_cycle(); IfReq = 1'b0; #1;

        // reset in the middle of a load
        next_cycle(); MemRead = 1'b1; MemAddr = 32'h4C; #1;
        next_cycle(); rst = 1'b1; #1;
        chk("rstacc_c1_en", RamEn, 1);
        next_cycle(); rst = 1'b0; #1;
        chk("rstacc_en", RamEn, 0);
        chk("rstacc_done", MemDone, 0);
        chk("rstacc_ifvalid", IfValid, 0);
        chk("rstacc_mrdata", MemRData, 0);
        chk("rstacc_irdata", IfRData, 0);
        chk("rstacc_addr", RamAddr, 0);
        chk("rstacc_memstall", MemStall, 1);
        for (int c = 3; c <= LAT + 2; c++) begin
            next_cycle(); #1;
            chk("rstacc_regrant_en", RamEn, 1);
            chk("rstacc_regrant_addr", RamAddr, 32'h4C);
        end
        next_cycle(); #1;
        chk("rstacc_done_after", MemDone, 1);
        chk("rstacc_rdata_after", MemRData, model_mem[19]);
        exp_mrd = model_mem[19];
        next_cycle(); MemRead = 1'b0; #1;

        // random transactions: 0 lw, 1 sw, 2 fetch, 3 lw+fetch, 4 sw+fetch
        for (int t = 0; t < 40; t++) begin
            kind   = int'($urandom_range(0, 4));
            do_mem = (kind != 2);
            do_wr  = (kind == 1) || (kind == 4);
            do_if  = (kind >= 2);
            d_idx  = 8'($urandom);
            i_idx  = ($urandom_range(0, 1) == 0) ? d_idx : 8'($urandom);
            d_addr = {22'($urandom), d_idx, 2'b00};
            i_addr = {22'($urandom), i_idx, 2'b00};
            wdat   = $urandom;

            exp_ld = model_mem[d_idx];
            if (do_mem && do_wr) model_mem[d_idx] = wdat;
            exp_ird = model_mem[i_idx];
            if (do_mem && !do_wr) exp_mrd = exp_ld;

            done_at = -1; valid_at = -1; pulses = 0;
            got_mrd = '0; got_ird = '0;
            for (int c = 0; c < 4 * LAT + 8; c++) begin
                next_cycle();
                if (c == 0) begin
                    MemRead  = do_mem && !do_wr;
                    MemWrite = do_mem && do_wr;
                    MemAddr  = d_addr;
                    MemWData = wdat;
                    IfReq    = do_if;
                    IfAddr   = i_addr;
                end
                if (done_at >= 0) begin
                    MemRead = 1'b0; MemWrite = 1'b0;
                end
                if (valid_at >= 0) IfReq = 1'b0;
                #1;
                if (MemDone === 1'b1) begin
                    pulses++;
                    if (done_at < 0) begin
                        done_at = c;
                        got_mrd = MemRData;
                    end
                end
                if (IfValid === 1'b1 && valid_at < 0) begin
                    valid_at = c;
                    got_ird  = IfRData;
                end
            end
            chk("rnd_done_cycle", 32'(done_at), do_mem ? 32'(LAT + 1) : 32'hFFFF_FFFF);
            chk("rnd_done_pulses", 32'(pulses), do_mem ? 32'd1 : 32'd0);
            chk("rnd_valid_cycle", 32'(valid_at),
                do_if ? (do_mem ? 32'(2 * LAT + 2) : 32'(LAT + 1)) : 32'hFFFF_FFFF);
            if (do_mem) chk("rnd_mrdata", got_mrd, exp_mrd);
            if (do_if) chk("rnd_irdata", got_ird, exp_ird);
            chk("rnd_quiet_valid", IfValid, 0);
            chk("rnd_quiet_en", RamEn, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
